// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad, synchronises and
// debounces the rows, and reports one stable key code plus a held level.
//
// Parameters:
//   SCAN_CYCLES      clk cycles each column is driven low (>= 4)
//   DEBOUNCE_CYCLES  consecutive stable cycles to accept a press or release
//   REPEAT_CYCLES    auto-repeat period while held (KEYPAD_REPEAT_EN only)
// Ports:
//   clk             in   master clock
//   rst             in   asynchronous reset, active-high
//   row[3:0]        in   keypad rows, active-low, row[0] = top row
//   col[3:0]        out  keypad columns, active-low one-hot, col[0] = left
//   dec[3:0]        out  code of the last accepted key
//   button_pressed  out  high while the accepted key is held (debounced)
// Build option:
//   KEYPAD_REPEAT_EN  when defined, button_pressed drops for one cycle every
//                     REPEAT_CYCLES while a key stays held.
module keypad_scanner #(
    parameter int unsigned SCAN_CYCLES     = 250000,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_CYCLES   = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] dec,
    output logic       button_pressed
);

    typedef enum logic [1:0] {
        SCAN    = 2'd0,
        CONFIRM = 2'd1,
        HELD    = 2'd2
    } state_t;

    localparam logic [31:0] SCAN_LAST = 32'(SCAN_CYCLES - 1);
    localparam logic [31:0] DEB_LAST  = 32'(DEBOUNCE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  sync_q;
    logic [3:0]  rs_q;
    logic [1:0]  col_idx_q, col_idx_d;
    logic [31:0] scan_cnt_q, scan_cnt_d;
    logic [31:0] cnt_q, cnt_d;
    logic [1:0]  cand_row_q, cand_row_d;
    logic [3:0]  dec_q, dec_d;
    logic        btn_q, btn_d;

    logic        slot_end;
    logic        hit;
    logic [1:0]  hit_row;
    logic        cand_low;
    logic        deb_done;
    logic [31:0] cnt_inc;

`ifdef KEYPAD_REPEAT_EN
    localparam logic [31:0] REP_LAST = 32'(REPEAT_CYCLES - 1);
    logic [31:0] rep_cnt_q, rep_cnt_d;
`else
    // Keeps the repeat period referenced in builds without auto-repeat.
    logic [31:0] rep_unused;
    assign rep_unused = 32'(REPEAT_CYCLES);
`endif

    function automatic logic [3:0] key_code(
        input logic [1:0] r,
        input logic [1:0] c
    );
        logic [3:0] code;
        code = 4'h0;
        unique case ({r, c})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'h0;
            4'hD: code = 4'hF;
            4'hE: code = 4'hE;
            4'hF: code = 4'hD;
        endcase
        return code;
    endfunction

    assign slot_end = (scan_cnt_q == SCAN_LAST);
    assign hit      = (rs_q != 4'hF);
    assign cand_low = ~rs_q[cand_row_q];
    assign deb_done = (cnt_q == DEB_LAST);
    // Saturating increment so the counter can never wrap back to zero.
    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;

    // Lowest row index wins when several rows are low.
    always_comb begin
        hit_row = 2'd3;
        if (!rs_q[0]) begin
            hit_row = 2'd0;
        end else if (!rs_q[1]) begin
            hit_row = 2'd1;
        end else if (!rs_q[2]) begin
            hit_row = 2'd2;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SCAN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SCAN: begin
                if (slot_end && hit) begin
                    state_d = CONFIRM;
                end
            end
            CONFIRM: begin
                if (!cand_low) begin
                    state_d = SCAN;
                end else if (deb_done) begin
                    state_d = HELD;
                end
            end
            HELD: begin
                if (!cand_low && deb_done) begin
                    state_d = SCAN;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    // Datapath next-state: scan position, debounce counter, result.
    always_comb begin
        col_idx_d  = col_idx_q;
        scan_cnt_d = scan_cnt_q;
        cnt_d      = cnt_q;
        cand_row_d = cand_row_q;
        dec_d      = dec_q;
        btn_d      = btn_q;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_d  = '0;
`endif
        unique case (state_q)
            SCAN: begin
                if (slot_end) begin
                    scan_cnt_d = '0;
                    if (hit) begin
                        cand_row_d = hit_row;
                        cnt_d      = '0;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end else begin
                    scan_cnt_d = scan_cnt_q + 32'd1;
                end
            end
            CONFIRM: begin
                if (!cand_low) begin
                    col_idx_d = col_idx_q + 2'd1;
                    cnt_d     = '0;
                end else if (deb_done) begin
                    dec_d = key_code(cand_row_q, col_idx_q);
                    btn_d = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            HELD: begin
                if (cand_low) begin
                    cnt_d = '0;
                end else if (deb_done) begin
                    btn_d     = 1'b0;
                    cnt_d     = '0;
                    col_idx_d = col_idx_q + 2'd1;
                end else begin
                    cnt_d = cnt_inc;
                end
`ifdef KEYPAD_REPEAT_EN
                // Release wins; btn_q low inside HELD marks a dropout cycle,
                // which does not count towards the next period.
                if (!(!cand_low && deb_done)) begin
                    if (!btn_q) begin
                        btn_d = 1'b1;
                    end else if (rep_cnt_q == REP_LAST) begin
                        btn_d = 1'b0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + 32'd1;
                    end
                end
`endif
            end
            default: ;
        endcase
    end

    // Idle rows are pulled up, so the synchroniser resets to all-high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= 4'hF;
            rs_q       <= 4'hF;
            col_idx_q  <= 2'd0;
            scan_cnt_q <= '0;
            cnt_q      <= '0;
            cand_row_q <= 2'd0;
            dec_q      <= 4'h0;
            btn_q      <= 1'b0;
        end else begin
            sync_q     <= row;
            rs_q       <= sync_q;
            col_idx_q  <= col_idx_d;
            scan_cnt_q <= scan_cnt_d;
            cnt_q      <= cnt_d;
            cand_row_q <= cand_row_d;
            dec_q      <= dec_d;
            btn_q      <= btn_d;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt_q <= '0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
        end
    end
`endif

    // Outputs.
    always_comb begin
        col            = ~(4'b0001 << col_idx_q);
        dec            = dec_q;
        button_pressed = btn_q;
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: self-checking bench for keypad_scanner with a
// behavioural keypad matrix and rule-level expectations.
module tb_keypad_scanner;

    localparam int SCAN = 4;
    localparam int DEB  = 8;
    localparam int REP  = 32;
    localparam int LAT  = 4 * SCAN + DEB + 3;
    localparam int REL  = DEB + 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  dec;
    logic        button_pressed;

    // keys[r*4+c] = 1 means the key at row r, column c is physically down.
    logic [15:0] keys = '0;

    int   checks   = 0;
    int   failures = 0;
    int   rises    = 0;
    logic bp_prev  = 1'b0;

    typedef struct {
        int         r;
        int         c;
        logic [3:0] code;
    } vec_t;

    vec_t vecs[16];

    always #5 clk = ~clk;

    // Pulled-up rows: a row reads low when a down key sits on a driven column.
    always_comb begin
        row[0] = ~|(keys[3:0]   & ~col);
        row[1] = ~|(keys[7:4]   & ~col);
        row[2] = ~|(keys[11:8]  & ~col);
        row[3] = ~|(keys[15:12] & ~col);
    end

    keypad_scanner #(
        .SCAN_CYCLES    (SCAN),
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_CYCLES  (REP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .row           (row),
        .col           (col),
        .dec           (dec),
        .button_pressed(button_pressed)
    );

    task automatic tick();
        @(negedge clk);
        if (button_pressed && !bp_prev) rises++;
        bp_prev = button_pressed;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_btn(input logic lvl, input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (button_pressed == lvl) begin
                n = i;
                break;
            end
        end
    endtask

    function automatic int kidx(input int r, input int c);
        return r * 4 + c;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

    initial begin
        int         n;
        int         r0;
        int         k;
        int         mism;
        int         lows;
        int         exp_lows;
        logic       exp_bp;
        logic [3:0] exp_col;
        logic [3:0] exp_dec;

        vecs[0]  = '{0, 0, 4'h1};
        vecs[1]  = '{0, 1, 4'h2};
        vecs[2]  = '{0, 2, 4'h3};
        vecs[3]  = '{0, 3, 4'hA};
        vecs[4]  = '{1, 0, 4'h4};
        vecs[5]  = '{1, 1, 4'h5};
        vecs[6]  = '{1, 2, 4'h6};
        vecs[7]  = '{1, 3, 4'hB};
        vecs[8]  = '{2, 0, 4'h7};
        vecs[9]  = '{2, 1, 4'h8};
        vecs[10] = '{2, 2, 4'h9};
        vecs[11] = '{2, 3, 4'hC};
        vecs[12] = '{3, 0, 4'h0};
        vecs[13] = '{3, 1, 4'hF};
        vecs[14] = '{3, 2, 4'hE};
        vecs[15] = '{3, 3, 4'hD};
        exp_dec = 4'h0;

        // Reset state and free-running column scan.
        #1 rst = 1'b1;
        tick();
        tick();
        chk("reset col", int'(col), 4'hE);
        chk("reset dec", int'(dec), 0);
        chk("reset button", int'(button_pressed), 0);
        rst = 1'b0;
        for (int s = 0; s < 20; s++) begin
            exp_col = ~(4'b0001 << ((s / SCAN) % 4));
            chk($sformatf("scan col s%0d", s), int'(col), int'(exp_col));
            tick();
        end
        chk("idle button", int'(button_pressed), 0);

        // Every key, one at a time.
        for (int i = 0; i < 16; i++) begin
            r0 = rises;
            keys = '0;
            keys[kidx(vecs[i].r, vecs[i].c)] = 1'b1;
            wait_btn(1'b1, LAT, n);
            chk($sformatf("key%0d accepted", i), int'(n > 0), 1);
            chk($sformatf("key%0d dec", i), int'(dec), int'(vecs[i].code));
            exp_dec = vecs[i].code;
            repeat (3) tick();
            keys = '0;
            wait_btn(1'b0, 2 * REL, n);
            chk($sformatf("key%0d release lat", i), n, REL);
            exp_col = ~(4'b0001 << ((vecs[i].c + 1) % 4));
            chk($sformatf("key%0d next col", i), int'(col), int'(exp_col));
            chk($sformatf("key%0d rises", i), rises - r0, 1);
            repeat (6) tick();
        end

        // 'A' bouncing every 3 clk, then steady.
        r0 = rises;
        keys = '0;
        keys[kidx(0, 3)] = 1'b1;
        for (int t = 0; t < 30; t++) begin
            tick();
            if ((t + 1) % 3 == 0) keys[kidx(0, 3)] = ~keys[kidx(0, 3)];
        end
        chk("bounce no early rise", rises - r0, 0);
        wait_btn(1'b1, LAT + 6, n);
        chk("bounce accepted", int'(n > 0), 1);
        chk("bounce dec", int'(dec), 4'hA);
        exp_dec = 4'hA;
        repeat (8) tick();
        keys = '0;
        wait_btn(1'b0, 2 * REL, n);
        chk("bounce release", n, REL);
        chk("bounce single rise", rises - r0, 1);
        repeat (4) tick();

        // 5-clk glitch on 'B'.
        r0 = rises;
        keys[kidx(1, 3)] = 1'b1;
        repeat (5) tick();
        keys = '0;
        repeat (20) tick();
        chk("glitch rises", rises - r0, 0);
        chk("glitch button", int'(button_pressed), 0);
        chk("glitch dec", int'(dec), int'(exp_dec));

        // '1' and '4' together: top row wins.
        r0 = rises;
        keys[kidx(0, 0)] = 1'b1;
        keys[kidx(1, 0)] = 1'b1;
        wait_btn(1'b1, LAT, n);
        chk("1+4 accepted", int'(n > 0), 1);
        chk("1+4 dec", int'(dec), 4'h1);
        exp_dec = 4'h1;
        repeat (3) tick();
        keys = '0;
        wait_btn(1'b0, 2 * REL, n);
        chk("1+4 release", n, REL);
        chk("1+4 rises", rises - r0, 1);
        repeat (4) tick();

        // '9' pressed while '2' is held; reported only after '2' is released.
        r0 = rises;
        keys[kidx(0, 1)] = 1'b1;
        wait_btn(1'b1, LAT, n);
        chk("2 accepted", int'(n > 0), 1);
        chk("2 dec", int'(dec), 4'h2);
        keys[kidx(2, 2)] = 1'b1;
        repeat (10) tick();
        chk("9 during 2 dec", int'(dec), 4'h2);
        chk("9 during 2 button", int'(button_pressed), 1);
        chk("9 during 2 rises", rises - r0, 1);
        keys[kidx(0, 1)] = 1'b0;
        wait_btn(1'b0, 2 * REL, n);
        chk("2 release", n, REL);
        wait_btn(1'b1, LAT, n);
        chk("9 accepted after", int'(n > 0), 1);
        chk("9 dec", int'(dec), 4'h9);
        exp_dec = 4'h9;
        keys = '0;
        wait_btn(1'b0, 2 * REL, n);
        chk("9 release", n, REL);
        chk("2/9 rises", rises - r0, 2);
        repeat (4) tick();

        // Asynchronous reset while '7' is held.
        keys[kidx(2, 0)] = 1'b1;
        wait_btn(1'b1, LAT, n);
        chk("7 accepted", int'(n > 0), 1);
        chk("7 dec", int'(dec), 4'h7);
        repeat (2) tick();
        rst = 1'b1;
        #1;
        chk("async rst col", int'(col), 4'hE);
        chk("async rst button", int'(button_pressed), 0);
        chk("async rst dec", int'(dec), 0);
        tick();
        rst = 1'b0;
        wait_btn(1'b1, LAT + 2, n);
        chk("7 re-accepted", int'(n > 0), 1);
        chk("7 re dec", int'(dec), 4'h7);
        keys = '0;
        wait_btn(1'b0, 2 * REL, n);
        chk("7 release", n, REL);
        exp_dec = 4'h7;
        repeat (4) tick();

        // 'C' held for 100 clk after acceptance: repeat dropouts or none.
        keys[kidx(2, 3)] = 1'b1;
        wait_btn(1'b1, LAT, n);
        chk("C accepted", int'(n > 0), 1);
        chk("C dec", int'(dec), 4'hC);
        exp_dec = 4'hC;
        mism = 0;
        lows = 0;
`ifdef KEYPAD_REPEAT_EN
        exp_lows = 3;
`else
        exp_lows = 0;
`endif
        for (int j = 1; j <= 100; j++) begin
            tick();
`ifdef KEYPAD_REPEAT_EN
            exp_bp = !(j == REP || j == 2 * REP + 1 || j == 3 * REP + 2);
`else
            exp_bp = 1'b1;
`endif
            if (!button_pressed) lows++;
            if (button_pressed != exp_bp) mism++;
        end
        chk("repeat low count", lows, exp_lows);
        chk("repeat pattern", mism, 0);
        keys = '0;
        wait_btn(1'b0, 2 * REL, n);
        chk("C release", n, REL);
        repeat (4) tick();

        // Randomised presses and glitches against rule-level expectations.
        for (int it = 0; it < 40; it++) begin
            k = $urandom_range(0, 15);
            r0 = rises;
            keys = '0;
            keys[k] = 1'b1;
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, DEB)) tick();
                keys = '0;
                repeat (12) tick();
                chk($sformatf("rand%0d glitch rises", it), rises - r0, 0);
                chk($sformatf("rand%0d glitch dec", it), int'(dec), int'(exp_dec));
            end else begin
                wait_btn(1'b1, LAT, n);
                chk($sformatf("rand%0d accepted", it), int'(n > 0), 1);
                exp_dec = vecs[k].code;
                chk($sformatf("rand%0d dec", it), int'(dec), int'(exp_dec));
                repeat ($urandom_range(1, 8)) tick();
                keys = '0;
                wait_btn(1'b0, 2 * REL, n);
                chk($sformatf("rand%0d release", it), n, REL);
                chk($sformatf("rand%0d rises", it), rises - r0, 1);
                repeat ($urandom_range(2, 10)) tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
